// File: rtl/sr_latch_driver_pkg.sv
// Shared definitions for the SR latch driver slice.
//   state_t      : driver FSM states, 2-bit encoding
//   LINE_ACTIVE  : level that asserts an active-low S_n/R_n line
//   LINE_IDLE    : level that leaves an S_n/R_n line released
//   cnt_width()  : counter width able to hold the largest cycle count
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam logic LINE_ACTIVE = 1'b0;
    localparam logic LINE_IDLE   = 1'b1;

    // Counters load N-1 and count down to zero, so they only need to hold
    // the largest of the three cycle counts. The +1 keeps a count of 1 at
    // one bit wide.
    function automatic int cnt_width(input int pulse_cycles,
                                     input int settle_cycles,
                                     input int timeout_cycles);
        int m;
        m = pulse_cycles;
        if (settle_cycles > m) m = settle_cycles;
        if (timeout_cycles > m) m = timeout_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Bundle of the request handshake, latch drive lines and latch feedback.
//   req_valid/req_level/req_ready : request handshake
//   S_n/R_n                       : active-low drive lines to the latch
//   Q_fb/Qbar_fb                  : latch outputs, asynchronous to clk
//   done/err/busy                 : completion pulse, sticky error, activity
//   dbg_state                     : current FSM state, for observation
//
// Handshake: a request transfers on the rising clk edge where req_valid
// and req_ready are both high. req_level is sampled only at that edge.
// req_ready is high only while the driver is idle; req_valid seen while
// req_ready is low is ignored and does not have to be held.
//
// slave  : the driver side (sr_latch_driver)
// master : the requester side, which also owns the latch feedback
interface sr_latch_driver_if;

    logic               req_valid;
    logic               req_level;
    logic               req_ready;
    logic               S_n;
    logic               R_n;
    logic               Q_fb;
    logic               Qbar_fb;
    logic               done;
    logic               err;
    logic               busy;
    sr_drv_pkg::state_t dbg_state;

    modport slave (
        input  req_valid, req_level, Q_fb, Qbar_fb,
        output req_ready, S_n, R_n, done, err, busy, dbg_state
    );

    modport master (
        output req_valid, req_level, Q_fb, Qbar_fb,
        input  req_ready, S_n, R_n, done, err, busy, dbg_state
    );

endinterface

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronized output, two clk edges of latency
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_driver.sv
// Write-side driver for an active-low cross-coupled NAND SR latch.
// Accepts a requested level, pulses S_n (level 1) or R_n (level 0) low for
// PULSE_CYCLES cycles, releases both lines for SETTLE_CYCLES cycles, then
// waits up to TIMEOUT_CYCLES cycles for synchronized Q/Qbar to match.
//   clk, rst : clock and synchronous active-high reset
//   bus      : sr_latch_driver_if.slave (handshake, lines, feedback, status)
// All outputs are registered.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    sr_latch_driver_if.slave   bus
);

    localparam int CNT_W = cnt_width(PULSE_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             s_n_r;
    logic             r_n_r;
    logic             ready_r;
    logic             done_r;
    logic             err_r;
    logic             busy_r;

    logic             q_s;
    logic             qbar_s;
    logic             fb_match;

    sync2 u_sync_q (
        .clk (clk),
        .rst (rst),
        .d   (bus.Q_fb),
        .q   (q_s)
    );

    sync2 u_sync_qbar (
        .clk (clk),
        .rst (rst),
        .d   (bus.Qbar_fb),
        .q   (qbar_s)
    );

    // Q==Qbar (forbidden or still resolving) can never satisfy both terms.
    assign fb_match = (q_s == level) && (qbar_s == ~level);

    // S_n and R_n are only ever driven active from the accept branch, and
    // each takes the opposite polarity of the same captured level, so both
    // low in one cycle cannot occur. Every other branch releases them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            level   <= 1'b0;
            s_n_r   <= LINE_IDLE;
            r_n_r   <= LINE_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_r) begin
                        level   <= bus.req_level;
                        err_r   <= 1'b0;
                        cnt     <= PULSE_LOAD;
                        state   <= PULSE;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        s_n_r   <= bus.req_level ? LINE_ACTIVE : LINE_IDLE;
                        r_n_r   <= bus.req_level ? LINE_IDLE : LINE_ACTIVE;
                    end
                end

                PULSE: begin
                    if (cnt == '0) begin
                        s_n_r <= LINE_IDLE;
                        r_n_r <= LINE_IDLE;
                        if (SETTLE_CYCLES == 0) begin
                            state <= CHECK;
                            cnt   <= TIMEOUT_LOAD;
                        end else begin
                            state <= SETTLE;
                            cnt   <= SETTLE_LOAD;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                SETTLE: begin
                    if (cnt == '0) begin
                        state <= CHECK;
                        cnt   <= TIMEOUT_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                CHECK: begin
                    if (fb_match) begin
                        state   <= IDLE;
                        done_r  <= 1'b1;
                        err_r   <= 1'b0;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else if (cnt == '0) begin
                        // Last allowed cycle without a match: give up.
                        state   <= IDLE;
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    s_n_r   <= LINE_IDLE;
                    r_n_r   <= LINE_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.S_n       = s_n_r;
    assign bus.R_n       = r_n_r;
    assign bus.req_ready = ready_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.busy      = busy_r;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver with a behavioural NAND SR latch on the lines.
module tb_sr_latch_driver;
    import sr_drv_pkg::*;

    localparam int P = 4;
    localparam int S = 2;
    localparam int T = 16;
    localparam int DONE_OK  = P + S + 2;
    localparam int DONE_ERR = P + S + 1 + T;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sr_latch_driver_if bus ();

    sr_latch_driver #(
        .PULSE_CYCLES   (P),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- latch model ----------------
    // force_mode: 0 = real latch, 1 = stuck Q=0/Qbar=1, 2 = Q=Qbar=1
    logic       latch_q;
    logic [1:0] force_mode;

    initial latch_q = 1'b0;

    always @(bus.S_n or bus.R_n) begin
        if (bus.S_n === 1'b0 && bus.R_n === 1'b1) latch_q = 1'b1;
        else if (bus.R_n === 1'b0 && bus.S_n === 1'b1) latch_q = 1'b0;
    end

    assign bus.Q_fb    = (force_mode == 2'd0) ? latch_q  :
                         (force_mode == 2'd1) ? 1'b0 : 1'b1;
    assign bus.Qbar_fb = (force_mode == 2'd0) ? ~latch_q : 1'b1;

    // ---------------- counters / scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int dones = 0;
    int both_low = 0;
    logic [1:0] exp_q[$];   // {expected err, expected latch Q}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.S_n === 1'b0 && bus.R_n === 1'b0) both_low++;
            assert (!(bus.S_n === 1'b0 && bus.R_n === 1'b0))
                else $error("S_n and R_n both low");
            if (bus.done === 1'b1) begin
                logic [1:0] e;
                dones++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done actual=1 expected=0");
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.err, latch_q} !== e) begin
                        errors++;
                        $display("FAIL sb_done_result actual=%b expected=%b", {bus.err, latch_q}, e);
                    end
                end
            end
            if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
                accepts++;
                exp_q.push_back({force_mode != 2'd0, bus.req_level});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from idle and check pulse window, other line,
    // done cycle, status in the done cycle and err stickiness afterwards.
    task automatic run_request(input logic lvl, input logic exp_err);
        int first_low, last_low, n_low, other_low, done_k;
        logic act_line, oth_line;
        first_low = -1; last_low = -1; n_low = 0; other_low = 0; done_k = -1;
        chk("ready_before_accept", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_level = lvl;
        tick();
        bus.req_valid = 1'b0;
        bus.req_level = ~lvl;   // must be ignored while busy
        for (int k = 1; k <= 60; k++) begin
            if (k == 1) chk("err_cleared_on_accept", 32'(bus.err), 32'd0);
            act_line = lvl ? bus.S_n : bus.R_n;
            oth_line = lvl ? bus.R_n : bus.S_n;
            if (act_line == 1'b0) begin
                if (first_low < 0) first_low = k;
                last_low = k;
                n_low++;
            end
            if (oth_line == 1'b0) other_low++;
            if (bus.done === 1'b1) begin
                done_k = k;
                break;
            end
            tick();
        end
        chk("pulse_first_cycle", 32'(first_low), 32'd1);
        chk("pulse_last_cycle", 32'(last_low), 32'(P));
        chk("pulse_length", 32'(n_low), 32'(P));
        chk("other_line_never_low", 32'(other_low), 32'd0);
        chk("done_cycle", 32'(done_k), exp_err ? 32'(DONE_ERR) : 32'(DONE_OK));
        chk("err_at_done", 32'(bus.err), 32'(exp_err));
        chk("ready_at_done", 32'(bus.req_ready), 32'd1);
        repeat (3) tick();
        chk("err_sticky", 32'(bus.err), 32'(exp_err));
        chk("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    typedef struct {
        logic       level;
        logic [1:0] fmode;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    // ---------------- test sequence ----------------
    initial begin
        int n;
        vecs[0] = '{1'b1, 2'd0, 1'b0};   // set
        vecs[1] = '{1'b0, 2'd0, 1'b0};   // reset
        vecs[2] = '{1'b0, 2'd0, 1'b0};   // redundant reset
        vecs[3] = '{1'b1, 2'd1, 1'b1};   // set, feedback stuck at reset
        vecs[4] = '{1'b1, 2'd2, 1'b1};   // set, Q==Qbar
        vecs[5] = '{1'b0, 2'd2, 1'b1};   // reset, Q==Qbar
        vecs[6] = '{1'b1, 2'd0, 1'b0};   // set, clears prior err

        rst = 1'b1;
        force_mode = 2'd0;
        bus.req_valid = 1'b0;
        bus.req_level = 1'b0;
        repeat (3) tick();
        chk("reset_S_n", 32'(bus.S_n), 32'd1);
        chk("reset_R_n", 32'(bus.R_n), 32'd1);
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_state", 32'(bus.dbg_state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // table-driven requests
        for (int i = 0; i < 7; i++) begin
            force_mode = vecs[i].fmode;
            tick();
            run_request(vecs[i].level, vecs[i].exp_err);
            force_mode = 2'd0;
        end
        chk("latch_after_table", 32'(latch_q), 32'd1);

        // back-to-back: valid held high across the done cycle
        bus.req_valid = 1'b1;
        bus.req_level = 1'b0;
        tick();
        n = 0;
        while (bus.done !== 1'b1 && n < 60) begin tick(); n++; end
        chk("b2b_first_done_cycle", 32'(n + 1), 32'(DONE_OK));
        chk("b2b_ready_in_done", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("b2b_second_R_n", 32'(bus.R_n), 32'd0);
        chk("b2b_second_S_n", 32'(bus.S_n), 32'd1);
        n = 0;
        while (bus.done !== 1'b1 && n < 60) begin tick(); n++; end
        chk("b2b_second_done", 32'(bus.done), 32'd1);
        tick();
        chk("latch_after_b2b", 32'(latch_q), 32'd0);

        // reset in the middle of a set pulse
        bus.req_valid = 1'b1;
        bus.req_level = 1'b1;
        tick();                       // accepted; now in T1
        bus.req_valid = 1'b0;
        chk("rst_mid_pulse_low_T1", 32'(bus.S_n), 32'd0);
        tick();                       // T2
        rst = 1'b1;
        tick();                       // T3
        chk("rst_mid_S_n", 32'(bus.S_n), 32'd1);
        chk("rst_mid_R_n", 32'(bus.R_n), 32'd1);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_err", 32'(bus.err), 32'd0);
        chk("rst_mid_state", 32'(bus.dbg_state), 32'(IDLE));
        chk("rst_mid_latch_kept", 32'(latch_q), 32'd1);
        rst = 1'b0;
        tick();

        // random stimulus
        accepts = 0;
        dones = 0;
        both_low = 0;
        for (int c = 0; c < 10000; c++) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_level = 1'($urandom_range(0, 1));
            tick();
        end
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 60) begin tick(); n++; end
        repeat (2) tick();
        chk("rand_drained", 32'(bus.busy), 32'd0);
        chk("rand_accepts_eq_dones", 32'(accepts), 32'(dones));
        chk("rand_some_accepts", 32'(accepts > 100), 32'd1);
        chk("rand_never_both_low", 32'(both_low), 32'd0);
        chk("sb_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Synchronous front end that drives an active-low cross-coupled NAND SR latch cell, acting as the write side of the latch's S/R interface. It accepts a requested level over a valid/ready handshake. It then issues a timed, glitch-free set or reset pulse and never asserts both lines. Finally it reads back the latch's Q/Qbar through synchronizers and reports done or error.

Parameters:
PULSE_CYCLES, 4, cycles S_n or R_n is held low per request (>=1)
SETTLE_CYCLES, 2, cycles both lines held high after the pulse, before checking (>=0)
TIMEOUT_CYCLES, 16, maximum CHECK-state cycles waiting for a feedback match (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_level  input  1  requested latch state: 1 = set (Q=1), 0 = reset (Q=0)
req_ready  output  1  driver idle and able to accept a request
S_n  output  1  active-low set line to the latch; idle high
R_n  output  1  active-low reset line to the latch; idle high
Q_fb  input  1  latch Q, asynchronous to clk
Qbar_fb  input  1  latch Qbar, asynchronous to clk
done  output  1  one-cycle pulse when a request completes (pass or fail)
err  output  1  feedback mismatch or timeout on the last request; sticky
busy  output  1  high in every non-IDLE state

Behaviour:
- Reset applies on a clk edge with rst=1.
  - Outputs: S_n=1, R_n=1, req_ready=1, done=0, err=0, busy=0; state=IDLE; counters and synchronizers cleared.
  - Reset mid-operation: S_n/R_n return high at that same edge; latch contents are not touched.
- All outputs are registered. S_n and R_n are never low in the same cycle, under any input or state.
- Q_fb and Qbar_fb each pass through a 2-flop synchronizer before any use.
- IDLE:
  - Outputs: req_ready=1, S_n=R_n=1.
  - Transition: the edge with req_valid&req_ready captures req_level, clears err, loads the counter, and moves to PULSE.
- PULSE: lasts exactly PULSE_CYCLES cycles, starting the cycle after the accept edge.
  - S_n=0 if the captured level is 1; otherwise R_n=0. The other line stays high.
  - Then go to SETTLE, or to CHECK if SETTLE_CYCLES=0.
- SETTLE: S_n=R_n=1 for SETTLE_CYCLES cycles, then CHECK.
- CHECK: S_n=R_n=1. Each cycle, compare the synchronized feedback.
  - Match when q_s==level and qbar_s==~level.
  - Match: go to IDLE; done=1 and req_ready=1 in the next cycle, err=0.
  - No match for TIMEOUT_CYCLES consecutive cycles: go to IDLE; done=1 and err=1 in the next cycle.
  - Q==Qbar (forbidden or metastable latch state) never counts as a match.
- Latency: accept at edge T0 → pulse during T1..T(PULSE_CYCLES). Best-case done cycle = T(PULSE_CYCLES+SETTLE_CYCLES+2).
- Back-to-back: req_ready is high in the done cycle. A request accepted at that edge starts a new PULSE in the next cycle, with no gap beyond that.
- Redundant request (latch already at the requested level): the full pulse is still issued. The sequence is deterministic and independent of prior state.
- req_level is sampled only at the accept edge. Changes while busy are ignored. req_valid while busy is not accepted.
- err stays set after done until the next accepted request clears it.
- Counters are sized $clog2(max(PULSE_CYCLES,SETTLE_CYCLES,TIMEOUT_CYCLES)+1) and load N-1. They cannot wrap.

Decomposition:
- Package sr_drv_pkg:
  - state enum {IDLE, PULSE, SETTLE, CHECK} with 2-bit encoding
  - LINE_ACTIVE=1'b0 and LINE_IDLE=1'b1 constants
  - helper function for counter width
- One sub-module, sync2: 2-flop synchronizer with the same clk/rst; instantiated twice, for Q_fb and Qbar_fb.
- FSM, counter and output registers live in sr_latch_driver.

Test Plan:
1. Bench: defaults, with a behavioural NAND SR latch model wired to S_n/R_n/Q_fb/Qbar_fb.
   Set request, accept at T0 → S_n=0 exactly during T1..T4, R_n=1 throughout; done=1, err=0 in T8; latch Q=1.
2. Reset request following test 1 → R_n=0 during T1..T4, S_n=1; done in T8; Q=0.
   Then hold req_valid high continuously → second request accepted at the done-cycle edge; R_n/S_n low again in the next cycle.
3. Feedback forced to Q_fb=0, Qbar_fb=1 on a set request → no match.
   - done=1, err=1 in cycle T(4+2+1+16)=T23.
   - err holds until the next accept edge, then clears.
4. Feedback forced to Q_fb=Qbar_fb=1 → treated as mismatch; timeout error as in test 3.
5. rst asserted in T2 of a set pulse → S_n=1 from T3; req_ready=1, busy=0, err=0. The latch model keeps Q=1.
6. Random req_valid/req_level stimulus for 10k cycles with an assertion → S_n and R_n are never both 0, and every accept yields exactly one done.
